// File: rtl/row_normalize.sv
// Gauss-Jordan pivot-row normalizer: scales each element of a row by the latched
// pivot reciprocal (signed fixed point) with round-half-up and saturation.
module row_normalize #(
    parameter int SIZE = 16,
    parameter int FRAC = 12,
    parameter int N    = 4,
    parameter int CW   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inv_valid,
    input  logic signed [SIZE-1:0] inv_in,
    input  logic                   in_valid,
    input  logic signed [SIZE-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [SIZE-1:0]        out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   row_done,
    output logic                   sat
);

    typedef enum logic [1:0] {IDLE, SCALE, DRAIN} state_t;

    localparam int PW = 2 * SIZE + 1;
    localparam logic signed [PW-1:0] HALF    = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [PW-1:0] MAX_VAL = {{(PW-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_VAL = {{(PW-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

    state_t                 state;
    logic [CW-1:0]          counter;
    logic signed [SIZE-1:0] inv_reg;
    logic signed [PW-1:0]   product;
    logic signed [PW-1:0]   rounded;
    logic signed [PW-1:0]   shifted;
    logic [SIZE-1:0]        scaled;
    logic                   scaled_sat;
    logic                   in_hs;
    logic                   out_hs;
    logic                   last_elem;

    assign in_ready  = (state == SCALE) && (!out_valid || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign last_elem = (counter == CW'(N - 1));

    // Full-width product keeps the rounding add and the arithmetic shift overflow-free.
    assign product = in_data * inv_reg;
    assign rounded = product + HALF;
    assign shifted = rounded >>> FRAC;

    always_comb begin
        scaled_sat = 1'b0;
        scaled     = shifted[SIZE-1:0];
        if (shifted > MAX_VAL) begin
            scaled     = MAX_VAL[SIZE-1:0];
            scaled_sat = 1'b1;
        end else if (shifted < MIN_VAL) begin
            scaled     = MIN_VAL[SIZE-1:0];
            scaled_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            inv_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            row_done  <= 1'b0;
            sat       <= 1'b0;
        end else begin
            row_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (inv_valid) begin
                        inv_reg <= inv_in;
                        counter <= '0;
                        sat     <= 1'b0;
                        state   <= SCALE;
                    end
                end
                SCALE: begin
                    // A new element may replace the one being taken downstream in the same cycle.
                    if (in_hs) begin
                        out_data  <= scaled;
                        out_valid <= 1'b1;
                        out_last  <= last_elem;
                        counter   <= counter + 1'b1;
                        if (scaled_sat) begin
                            sat <= 1'b1;
                        end
                        if (last_elem) begin
                            state <= DRAIN;
                        end
                    end else if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        row_done  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_normalize.sv
// Randomized self-checking bench for row_normalize: a transaction-level model
// predicts every output, handshake and status flag each cycle.
module tb_row_normalize;

    localparam int SIZE = 16;
    localparam int FRAC = 12;
    localparam int N    = 4;
    localparam int CW   = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   inv_valid = 1'b0;
    logic signed [SIZE-1:0] inv_in = '0;
    logic                   in_valid = 1'b0;
    logic signed [SIZE-1:0] in_data = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic [SIZE-1:0]        out_data;
    logic                   out_last;
    logic                   out_ready = 1'b0;
    logic                   busy;
    logic                   row_done;
    logic                   sat;

    row_normalize #(.SIZE(SIZE), .FRAC(FRAC), .N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .inv_valid(inv_valid), .inv_in(inv_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .row_done(row_done), .sat(sat)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] out_log[$];
    int          out_cyc[$];
    int          phase = 0;
    int          accepted = 0;
    logic [15:0] model_inv = '0;
    logic        model_sat = 1'b0;
    logic        exp_row_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, actual, expected);
        end
    endtask

    // Q4.12 scaling from first principles: exact product, add half an LSB, floor-divide, clamp.
    function automatic logic [15:0] modelF(input logic [15:0] x, input logic [15:0] inv, output logic saturated);
        longint p;
        longint num;
        longint r;
        p   = longint'($signed(x)) * longint'($signed(inv));
        num = p + 2048;
        if (num >= 0) r = num / 4096;
        else r = -((-num + 4095) / 4096);
        saturated = 1'b0;
        if (r > 32767) begin
            r = 32767;
            saturated = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            saturated = 1'b1;
        end
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        int   cur_phase;
        logic s;
        logic [15:0] d;
        if (rst) begin
            expq.delete();
            phase        = 0;
            accepted     = 0;
            model_sat    = 1'b0;
            exp_row_done = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            cur_phase = phase;
            checkOutput("busy", {31'd0, busy}, {31'd0, cur_phase != 0});
            checkOutput("in_ready", {31'd0, in_ready},
                        {31'd0, (cur_phase == 1) && (!out_valid || out_ready)});
            checkOutput("row_done", {31'd0, row_done}, {31'd0, exp_row_done});
            checkOutput("sat", {31'd0, sat}, {31'd0, model_sat});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expq.size() != 0});
            if (prev_stall)
                checkOutput("stall_hold", {14'd0, out_valid, out_last, out_data}, {14'd0, 1'b1, prev_last, prev_data});
            if (out_valid && expq.size() != 0) begin
                checkOutput("out_data", {16'd0, out_data}, {16'd0, expq[0].data});
                checkOutput("out_last", {31'd0, out_last}, {31'd0, expq[0].last});
            end
            exp_row_done = 1'b0;
            if (out_valid && out_ready && expq.size() != 0) begin
                out_log.push_back(out_data);
                out_cyc.push_back(cycle);
                if (expq[0].last) begin
                    exp_row_done = 1'b1;
                    phase = 0;
                end
                void'(expq.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (cur_phase == 0 && inv_valid) begin
                model_inv = inv_in;
                model_sat = 1'b0;
                accepted  = 0;
                phase     = 1;
            end
            if (cur_phase == 1 && in_valid && in_ready) begin
                d = modelF(in_data, model_inv, s);
                model_sat = model_sat | s;
                expq.push_back('{data: d, last: (accepted == N - 1)});
                accepted++;
                if (accepted == N) phase = 2;
            end
        end
    end

    task automatic pulseInv(input logic [15:0] inv);
        if (!row_done) begin
            @(posedge clk); #1;
        end
        inv_valid = 1'b1;
        inv_in    = inv;
        @(posedge clk); #1;
        inv_valid = 1'b0;
        inv_in    = 16'($urandom);
    endtask

    // Streams one row and keeps going until row_done is seen; ends one step after the row_done edge.
    task automatic applyStimulus(input logic [15:0] inv, input logic [15:0] elems [4],
                                 input int in_pct, input int out_pct, input int stall_start,
                                 input bit inject_inv);
        int idx = 0;
        int cyc = 0;
        out_log.delete();
        out_cyc.delete();
        pulseInv(inv);
        while (!(idx == N && row_done) && cyc < 200) begin
            in_valid  = (idx < N) && ($urandom_range(0, 99) < in_pct);
            in_data   = (idx < N) ? elems[idx] : 16'($urandom);
            out_ready = (cyc >= stall_start && cyc < stall_start + 3) ? 1'b0
                        : ($urandom_range(0, 99) < out_pct);
            inv_valid = inject_inv && (cyc == 1 || cyc == 3);
            inv_in    = inject_inv ? 16'h2000 : 16'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        inv_valid = 1'b0;
        if (cyc >= 200) checkOutput("row_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic checkLog(input string name, input logic [15:0] e [4]);
        checkOutput({name, "_count"}, 32'(out_log.size()), 32'd4);
        if (out_log.size() == 4)
            for (int i = 0; i < 4; i++) checkOutput(name, {16'd0, out_log[i]}, {16'd0, e[i]});
    endtask

    initial begin
        logic        s;
        logic [15:0] r;
        logic [15:0] elems [4];

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out", {26'd0, in_ready, out_valid, out_last, busy, row_done, sat}, 32'd0);
        checkOutput("reset_data", {16'd0, out_data}, 32'd0);
        rst = 1'b0;

        r = modelF(16'h0003, 16'h0800, s);
        checkOutput("model_round", {15'd0, s, r}, {15'd0, 1'b0, 16'h0002});
        r = modelF(16'h8000, 16'h4000, s);
        checkOutput("model_sat", {15'd0, s, r}, {15'd0, 1'b1, 16'h8000});

        // Basic row at full rate.
        applyStimulus(16'h0800, '{16'h1000, 16'h2000, 16'hF000, 16'h0003}, 100, 100, 99, 0);
        checkLog("basic", '{16'h0800, 16'h1000, 16'hF800, 16'h0002});
        checkOutput("basic_sat", {31'd0, sat}, 32'd0);

        // Saturation, sat sticky to row end.
        applyStimulus(16'h4000, '{16'h3000, 16'h8000, 16'h0400, 16'hFC00}, 100, 100, 99, 0);
        checkLog("satrow", '{16'h7FFF, 16'h8000, 16'h1000, 16'hF000});
        checkOutput("satrow_sat", {31'd0, sat}, 32'd1);

        // Backpressure mid-row.
        applyStimulus(16'h0800, '{16'h1000, 16'h2000, 16'hF000, 16'h0003}, 100, 100, 2, 0);
        checkLog("stall", '{16'h0800, 16'h1000, 16'hF800, 16'h0002});

        // inv_valid ignored mid-row, then re-armed in the row_done cycle.
        applyStimulus(16'h0800, '{16'h1000, 16'h2000, 16'hF000, 16'h0003}, 100, 100, 99, 1);
        checkLog("ignore", '{16'h0800, 16'h1000, 16'hF800, 16'h0002});
        applyStimulus(16'h2000, '{16'h1000, 16'h2000, 16'hF000, 16'h0003}, 100, 100, 99, 0);
        checkLog("rearm", '{16'h2000, 16'h4000, 16'hE000, 16'h0006});

        // Asynchronous reset after two elements accepted.
        pulseInv(16'h4000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 16'h3000;
        @(posedge clk); #1;
        in_data = 16'h1000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid", {28'd0, out_valid, busy, in_ready, sat}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(16'h0800, '{16'h1000, 16'h2000, 16'hF000, 16'h0003}, 100, 100, 99, 0);
        checkLog("post_rst", '{16'h0800, 16'h1000, 16'hF800, 16'h0002});
        checkOutput("throughput", 32'(out_cyc[3] - out_cyc[0]), 32'd3);

        // Randomized rows with random gaps and backpressure.
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 4; i++) begin
                elems[i] = 16'($urandom);
                if ($urandom_range(0, 3) == 0) elems[i] = 16'($signed(elems[i]) >>> 6);
            end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            applyStimulus(16'($urandom), elems, $urandom_range(40, 100), $urandom_range(40, 100),
                          $urandom_range(0, 12), $urandom_range(0, 1) == 1);
            checkOutput("rand_count", 32'(out_log.size()), 32'd4);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
